// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing a single data-memory read/write channel among LSU consumers.
// One transaction in flight at a time; all channel and consumer outputs are registered.
module dmem_rr_arbiter #(
   parameter int ADDR_BITS     = 8,
   parameter int DATA_BITS     = 8,
   parameter int NUM_CONSUMERS = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
   output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
   output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
   input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
   input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
   input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
   output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
   output logic                                    mem_read_valid,
   output logic [ADDR_BITS-1:0]                    mem_read_address,
   input  logic                                    mem_read_ready,
   input  logic [DATA_BITS-1:0]                    mem_read_data,
   output logic                                    mem_write_valid,
   output logic [ADDR_BITS-1:0]                    mem_write_address,
   output logic [DATA_BITS-1:0]                    mem_write_data,
   input  logic                                    mem_write_ready,
   output logic                                    busy,
   output logic [$clog2(NUM_CONSUMERS)-1:0]        grant_id
);

   localparam int                 ID_BITS = $clog2(NUM_CONSUMERS);
   localparam int unsigned        NC      = NUM_CONSUMERS;
   localparam logic [ID_BITS-1:0] LAST_ID = ID_BITS'(NUM_CONSUMERS - 1);

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

   state_t                                  state_q, state_d;
   logic [ID_BITS-1:0]                      rr_ptr_q, rr_ptr_d;
   logic [ID_BITS-1:0]                      grant_d;
   logic                                    op_write_q, op_write_d;
   logic                                    mem_read_valid_d, mem_write_valid_d;
   logic [ADDR_BITS-1:0]                    mem_read_addr_d, mem_write_addr_d;
   logic [DATA_BITS-1:0]                    mem_write_data_d;
   logic [NUM_CONSUMERS-1:0]                read_ready_d, write_ready_d;
   logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_d;

   logic                                    found;
   logic [ID_BITS-1:0]                      pick;
   logic [ID_BITS-1:0]                      scan_id;
   int unsigned                             scan_sum;
   logic                                    served_valid;

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      grant_d           = grant_id;
      op_write_d        = op_write_q;
      mem_read_valid_d  = mem_read_valid;
      mem_read_addr_d   = mem_read_address;
      mem_write_valid_d = mem_write_valid;
      mem_write_addr_d  = mem_write_address;
      mem_write_data_d  = mem_write_data;
      read_ready_d      = consumer_read_ready;
      write_ready_d     = consumer_write_ready;
      read_data_d       = consumer_read_data;
      found             = 1'b0;
      pick              = '0;
      scan_id           = '0;
      scan_sum          = 0;
      served_valid      = op_write_q ? consumer_write_valid[grant_id]
                                     : consumer_read_valid[grant_id];

      // Scan from rr_ptr with wrap; first requester (read or write) wins.
      for (int unsigned k = 0; k < NC; k++) begin
         scan_sum = 32'(rr_ptr_q) + k;
         if (scan_sum >= NC) scan_sum = scan_sum - NC;
         scan_id = ID_BITS'(scan_sum);
         if (!found && (consumer_read_valid[scan_id] || consumer_write_valid[scan_id])) begin
            found = 1'b1;
            pick  = scan_id;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d = pick;
               if (consumer_read_valid[pick]) begin
                  state_d          = READ_WAIT;
                  op_write_d       = 1'b0;
                  mem_read_valid_d = 1'b1;
                  mem_read_addr_d  = consumer_read_address[pick];
               end else begin
                  state_d           = WRITE_WAIT;
                  op_write_d        = 1'b1;
                  mem_write_valid_d = 1'b1;
                  mem_write_addr_d  = consumer_write_address[pick];
                  mem_write_data_d  = consumer_write_data[pick];
               end
            end
         end
         READ_WAIT: begin
            if (mem_read_ready) begin
               mem_read_valid_d      = 1'b0;
               read_data_d[grant_id] = mem_read_data;
               read_ready_d[grant_id] = 1'b1;
               state_d               = RELAY;
            end
         end
         WRITE_WAIT: begin
            if (mem_write_ready) begin
               mem_write_valid_d       = 1'b0;
               write_ready_d[grant_id] = 1'b1;
               state_d                 = RELAY;
            end
         end
         RELAY: begin
            // Pointer advances only on release so a pending write on the same consumer waits a full round.
            if (!served_valid) begin
               read_ready_d  = '0;
               write_ready_d = '0;
               rr_ptr_d      = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
               state_d       = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q              <= IDLE;
         rr_ptr_q             <= '0;
         grant_id             <= '0;
         op_write_q           <= 1'b0;
         mem_read_valid       <= 1'b0;
         mem_read_address     <= '0;
         mem_write_valid      <= 1'b0;
         mem_write_address    <= '0;
         mem_write_data       <= '0;
         consumer_read_ready  <= '0;
         consumer_write_ready <= '0;
         consumer_read_data   <= '0;
      end else begin
         state_q              <= state_d;
         rr_ptr_q             <= rr_ptr_d;
         grant_id             <= grant_d;
         op_write_q           <= op_write_d;
         mem_read_valid       <= mem_read_valid_d;
         mem_read_address     <= mem_read_addr_d;
         mem_write_valid      <= mem_write_valid_d;
         mem_write_address    <= mem_write_addr_d;
         mem_write_data       <= mem_write_data_d;
         consumer_read_ready  <= read_ready_d;
         consumer_write_ready <= write_ready_d;
         consumer_read_data   <= read_data_d;
      end
   end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Scoreboard bench for dmem_rr_arbiter: randomized consumers, a latency-randomized memory,
// and a round-robin reference model that predicts every grant from the driven request set.
module tb_dmem_rr_arbiter;

   localparam int NC      = 4;
   localparam int OP_RD   = 0;
   localparam int OP_WR   = 1;
   localparam int OP_BOTH = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NC-1:0]      rv, wv;
   logic [NC-1:0][7:0] ra, wa, wd;
   logic [NC-1:0]      consumer_read_ready, consumer_write_ready;
   logic [NC-1:0][7:0] consumer_read_data;
   logic               mem_read_valid, mem_write_valid;
   logic               mem_read_ready, mem_write_ready;
   logic [7:0]         mem_read_address, mem_write_address, mem_write_data, mem_read_data;
   logic               busy;
   logic [1:0]         grant_id;

   int n_pass  = 0;
   int n_total = 0;
   int fixed_wait = -1;

   logic [7:0] exp_rd_q [NC][$];
   int         exp_wr_q [NC][$];

   dmem_rr_arbiter #(
      .ADDR_BITS     (8),
      .DATA_BITS     (8),
      .NUM_CONSUMERS (NC)
   ) dut (
      .clk                    (clk),
      .reset                  (reset),
      .consumer_read_valid    (rv),
      .consumer_read_address  (ra),
      .consumer_read_ready    (consumer_read_ready),
      .consumer_read_data     (consumer_read_data),
      .consumer_write_valid   (wv),
      .consumer_write_address (wa),
      .consumer_write_data    (wd),
      .consumer_write_ready   (consumer_write_ready),
      .mem_read_valid         (mem_read_valid),
      .mem_read_address       (mem_read_address),
      .mem_read_ready         (mem_read_ready),
      .mem_read_data          (mem_read_data),
      .mem_write_valid        (mem_write_valid),
      .mem_write_address      (mem_write_address),
      .mem_write_data         (mem_write_data),
      .mem_write_ready        (mem_write_ready),
      .busy                   (busy),
      .grant_id               (grant_id)
   );

   always #5 clk = ~clk;

   // Read-side memory contents are a fixed function of the address.
   function automatic logic [7:0] rom(input logic [7:0] a);
      return a ^ 8'h2F;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},            busy, 0);
      check({tag, "_grant_id"},        grant_id, 0);
      check({tag, "_mem_valids"},      {mem_read_valid, mem_write_valid}, 0);
      check({tag, "_mem_read_addr"},   mem_read_address, 0);
      check({tag, "_mem_write_addr"},  mem_write_address, 0);
      check({tag, "_mem_write_data"},  mem_write_data, 0);
      check({tag, "_readies"},         {consumer_read_ready, consumer_write_ready}, 0);
      check({tag, "_read_data"},       consumer_read_data, 0);
   endtask

   // ---------------- memory responder ----------------
   initial begin : mem_model
      logic r_act, w_act;
      int   rcnt, wcnt, rwait, wwait;
      r_act = 1'b0; w_act = 1'b0; rcnt = 0; wcnt = 0; rwait = 0; wwait = 0;
      mem_read_ready = 1'b0; mem_write_ready = 1'b0; mem_read_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_read_ready = 1'b0; mem_write_ready = 1'b0; r_act = 1'b0; w_act = 1'b0;
         end else begin
            if (mem_read_ready) mem_read_ready = 1'b0;
            else if (mem_read_valid) begin
               if (!r_act) begin
                  r_act = 1'b1; rcnt = 0;
                  rwait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
               end
               if (rcnt == rwait) begin
                  mem_read_ready = 1'b1; mem_read_data = rom(mem_read_address); r_act = 1'b0;
               end else rcnt++;
            end
            if (!mem_read_ready) mem_read_data = 8'($urandom);
            if (mem_write_ready) mem_write_ready = 1'b0;
            else if (mem_write_valid) begin
               if (!w_act) begin
                  w_act = 1'b1; wcnt = 0;
                  wwait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
               end
               if (wcnt == wwait) begin
                  mem_write_ready = 1'b1; w_act = 1'b0;
               end else wcnt++;
            end
         end
      end
   end

   // ---------------- grant predictor / channel monitor ----------------
   initial begin : grant_mon
      int            model_rr, w, idx;
      logic          prev_r, prev_w, new_r, new_w;
      logic [NC-1:0] s_rv, s_wv;
      logic [NC-1:0][7:0] s_ra, s_wa, s_wd;
      model_rr = 0; prev_r = 1'b0; prev_w = 1'b0;
      forever begin
         @(posedge clk);
         s_rv = rv; s_wv = wv; s_ra = ra; s_wa = wa; s_wd = wd;
         #1;
         if (reset) begin
            model_rr = 0; prev_r = 1'b0; prev_w = 1'b0;
         end else begin
            check("one_mem_request", mem_read_valid & mem_write_valid, 0);
            check("one_ready_bit", ($countones({consumer_read_ready, consumer_write_ready}) <= 1), 1);
            new_r = mem_read_valid & ~prev_r;
            new_w = mem_write_valid & ~prev_w;
            if (new_r || new_w) begin
               w = -1;
               for (int k = 0; k < NC; k++) begin
                  idx = (model_rr + k) % NC;
                  if (w < 0 && (s_rv[idx] || s_wv[idx])) w = idx;
               end
               if (w < 0) check("grant_without_request", 1, 0);
               else begin
                  check("grant_id", grant_id, w);
                  check("grant_is_write", new_w, !s_rv[w]);
                  if (s_rv[w]) check("mem_read_address", mem_read_address, s_ra[w]);
                  else begin
                     check("mem_write_address", mem_write_address, s_wa[w]);
                     check("mem_write_data", mem_write_data, s_wd[w]);
                  end
                  model_rr = (w + 1) % NC;
               end
            end
            prev_r = mem_read_valid;
            prev_w = mem_write_valid;
         end
      end
   end

   // ---------------- consumer response monitor ----------------
   initial begin : resp_mon
      logic [NC-1:0] prev_rr, prev_wr;
      prev_rr = '0; prev_wr = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_rr = '0; prev_wr = '0;
         end else begin
            for (int i = 0; i < NC; i++) begin
               if (consumer_read_ready[i] && !prev_rr[i]) begin
                  if (exp_rd_q[i].size() == 0) check("unexpected_read_ready", 1, 0);
                  else check("consumer_read_data", consumer_read_data[i], exp_rd_q[i].pop_front());
               end
               if (consumer_write_ready[i] && !prev_wr[i]) begin
                  if (exp_wr_q[i].size() == 0) check("unexpected_write_ready", 1, 0);
                  else void'(exp_wr_q[i].pop_front());
               end
            end
            prev_rr = consumer_read_ready;
            prev_wr = consumer_write_ready;
         end
      end
   end

   // ---------------- consumer driver tasks ----------------
   task automatic wait_ready(input int c, input logic is_wr, output int n);
      logic rdy;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         rdy = is_wr ? consumer_write_ready[c] : consumer_read_ready[c];
      end while (!rdy && n < 400);
      if (!rdy) check("ready_timeout", 0, 1);
   endtask

   task automatic hold_phase(input int c, input logic is_wr, input int hold);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_ready", is_wr ? consumer_write_ready[c] : consumer_read_ready[c], 1);
         check("hold_no_mem_request", {mem_read_valid, mem_write_valid}, 0);
      end
   endtask

   task automatic do_txn(input int c, input int op, input logic [7:0] raddr,
                         input logic [7:0] waddr, input logic [7:0] wdata,
                         input int hold, output int lat);
      int n;
      lat = 0;
      @(negedge clk);
      if (op != OP_WR) begin
         rv[c] = 1'b1; ra[c] = raddr; exp_rd_q[c].push_back(rom(raddr));
      end
      if (op != OP_RD) begin
         wv[c] = 1'b1; wa[c] = waddr; wd[c] = wdata; exp_wr_q[c].push_back(int'(waddr));
      end
      if (op != OP_WR) begin
         wait_ready(c, 1'b0, n); lat = n;
         hold_phase(c, 1'b0, hold);
         rv[c] = 1'b0;
      end
      if (op != OP_RD) begin
         wait_ready(c, 1'b1, n);
         if (op == OP_WR) lat = n;
         hold_phase(c, 1'b1, hold);
         wv[c] = 1'b0;
      end
   endtask

   task automatic rd_burst(input int c, input int count);
      int lat;
      repeat (count) do_txn(c, OP_RD, 8'($urandom), 8'h00, 8'h00, 0, lat);
   endtask

   task automatic rand_worker(input int c);
      int lat;
      repeat (12) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_txn(c, int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), lat);
      end
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NC; i++) begin
         exp_rd_q[i].delete();
         exp_wr_q[i].delete();
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got no completion, required finish before timeout");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin : main
      int lat, n;
      reset = 1'b1; rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      // Single read on consumer 2 with three memory wait cycles.
      fixed_wait = 3;
      do_txn(2, OP_RD, 8'h05, 8'h00, 8'h00, 0, lat);
      check("c2_latency", lat, 5);
      check("c2_read_data", consumer_read_data[2], 8'h2A);

      // Quiet period: nothing moves, grant_id keeps its last value.
      repeat (10) begin
         @(negedge clk);
         check("idle_busy", busy, 0);
         check("idle_mem_valids", {mem_read_valid, mem_write_valid}, 0);
         check("idle_grant_id", grant_id, 2);
      end

      // Pointer sits at 3 after consumer 2, so 3 beats 0.
      fixed_wait = -1;
      fork
         do_txn(0, OP_RD, 8'h10, 8'h00, 8'h00, 0, n);
         do_txn(3, OP_RD, 8'h13, 8'h00, 8'h00, 0, lat);
      join
      check("c2_data_held", consumer_read_data[2], 8'h2A);

      // Simultaneous read and write from consumer 1: read first, write later.
      do_txn(1, OP_BOTH, 8'h08, 8'h09, 8'h11, 1, lat);

      // Consumer 0 holds valid four cycles past ready with zero memory wait.
      fixed_wait = 0;
      do_txn(0, OP_RD, 8'h20, 8'h00, 8'h00, 4, lat);
      check("c0_min_latency", lat, 2);

      // All four reading continuously from reset.
      @(negedge clk) reset = 1'b1;
      @(negedge clk) begin clear_queues(); reset = 1'b0; end
      fixed_wait = -1;
      fork
         rd_burst(0, 2);
         rd_burst(1, 2);
         rd_burst(2, 2);
         rd_burst(3, 2);
      join

      // Reset while consumer 3 is waiting on memory.
      fixed_wait = 20;
      @(negedge clk);
      rv[3] = 1'b1; ra[3] = 8'h33;
      n = 0;
      while (!mem_read_valid && n < 50) begin @(negedge clk); n++; end
      check("c3_granted", grant_id, 3);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      #1 check_all_zero("midreset");
      @(negedge clk);
      rv[3] = 1'b0;
      clear_queues();
      fixed_wait = -1;
      @(negedge clk) reset = 1'b0;
      fork
         do_txn(1, OP_RD, 8'h41, 8'h00, 8'h00, 0, n);
         do_txn(3, OP_RD, 8'h43, 8'h00, 8'h00, 0, lat);
         begin
            int t;
            t = 0;
            while (!mem_read_valid && t < 50) begin @(negedge clk); t++; end
            check("post_reset_first_grant", grant_id, 1);
         end
      join

      // Randomized concurrent traffic.
      fork
         rand_worker(0);
         rand_worker(1);
         rand_worker(2);
         rand_worker(3);
      join

      repeat (5) @(negedge clk);
      for (int i = 0; i < NC; i++) begin
         check("read_queue_drained", exp_rd_q[i].size(), 0);
         check("write_queue_drained", exp_wr_q[i].size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
